mux_stream: RTL and testbench
=============================

Name: mux_stream

Overview:
- Parametrised N-input, WIDTH-bit registered selector with per-channel valid/ready handshakes.
- Successor to the fixed 4:1 combinational 32-bit datapath mux.
- Two selection modes: external select (fixed) or round-robin arbitration.
- Result is held in a single output register. Intended for datapath/bus sharing where sources can stall.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels. Legal range 2..16.
- SEL_W, 2, select width. Must equal ceil(log2(NUM_IN)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational.
- sel  input  SEL_W  channel select used when mode=0.
- mode  input  1  0 = fixed select, 1 = round-robin.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_sel  output  SEL_W  index of the channel that sourced out_data; registered.

Behaviour:
- Reset state (rst_n=0 at a clock edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=NUM_IN-1. With this pointer, channel 0 has first round-robin priority.
- load_en = !out_valid || out_ready. Full-throughput single stage: a load and a drain may occur in the same cycle.
- Grant, mode=0:
  - g = sel, valid only if sel < NUM_IN and in_valid[sel]=1.
  - sel >= NUM_IN never grants.
- Grant, mode=1:
  - g = first i with in_valid[i]=1, searching (rr_ptr+1) to (rr_ptr+NUM_IN), each taken modulo NUM_IN.
  - No valid channel means no grant.
- Handshake:
  - in_ready[g] = load_en && grant.
  - All other in_ready bits = 0.
  - No in_ready bit asserts while out_valid=1 and out_ready=0.
- Transfer (grant && load_en):
  - Next cycle: out_data = channel g data, out_sel = g, out_valid = 1.
  - In mode 1 only, rr_ptr <= g.
- Drain without grant (out_valid && out_ready && !grant): out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_data, out_valid and out_sel hold. Changes to sel or mode during a stall do not affect held data.
- Latency: input accept to out_valid is 1 cycle. Maximum throughput is 1 beat per cycle.
- Mode switch: takes effect on the next grant evaluation. rr_ptr is retained across mode changes and is not updated in mode 0.
- rr_ptr wraps from NUM_IN-1 to 0.
- Reset mid-transfer: in-flight output is discarded. in_ready is 0 during reset.

Optional Feature:
- Macro: MUX_STREAM_LOCK_EN.
- Defined:
  - Adds input port in_last (width NUM_IN).
  - In mode=1, after a transfer from channel g with in_last[g]=0, a lock flag is set. While locked, the grant is restricted to channel g even if other channels are valid.
  - Lock clears on the transfer with in_last[g]=1; rr_ptr then advances to g.
  - Lock clears on reset and whenever mode=0.
  - Mode=0 ignores in_last.
- Undefined: no in_last port, no lock state. Every beat is arbitrated independently.

Test Plan:
- Fixed select, no stall: mode=0, sel=2, in_valid=4'b1111, channel 2 data=32'hCAFE0002, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hCAFE0002, out_sel=2, out_valid=1.
- Round-robin fairness: mode=1, in_valid=4'b1011 held, out_ready=1 from reset -> out_sel sequence 0,1,3,0,1,3; channel 2 is never granted.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with all inputs valid -> in_ready=0 throughout; out_data unchanged. On out_ready=1, the next beat is accepted in that same cycle.
- Out-of-range / empty: NUM_IN=3, SEL_W=2, sel=3, mode=0 -> no in_ready asserted; out_valid falls to 0 after the pending beat drains.
- Reset mid-operation: rst_n=0 for one edge while out_valid=1, out_ready=0 -> out_valid=0, out_data=0. The first round-robin grant after reset goes to channel 0.
- (MUX_STREAM_LOCK_EN) mode=1, channels 0 and 1 valid, channel 0 sends 3 beats with in_last on the third -> out_sel 0,0,0,1.

Source files
------------

// File: rtl/mux_stream.sv
// mux_stream -- parametrised N-input registered stream selector.
//
// Picks one of NUM_IN valid/ready input channels, either the channel named
// by `sel` (mode=0) or by round-robin arbitration (mode=1). The chosen beat
// is captured in a single output register. That register can load and drain
// in the same cycle, so a stream can move one beat per clock.
//
// Optional build macro: MUX_STREAM_LOCK_EN
//   When defined, the block gains the in_last port. In round-robin mode a
//   channel keeps the grant from its first beat until the beat that carries
//   in_last.
//
// Parameters:
//   WIDTH   data width per channel
//   NUM_IN  number of input channels (2..16)
//   SEL_W   select width, ceil(log2(NUM_IN))
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet (MUX_STREAM_LOCK_EN only)
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   sel        channel select used in mode 0
//   mode       0 = fixed select, 1 = round-robin
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  downstream ready
//   out_sel    registered index of the channel that sourced out_data
module mux_stream #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
`ifdef MUX_STREAM_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
`endif
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic [WIDTH-1:0] ch_data [NUM_IN];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

`ifdef MUX_STREAM_LOCK_EN
  logic lock_q, lock_d;
`endif

  logic             fx_hit;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic             grant;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  // A select value beyond the last channel never grants.
  assign fx_hit = (int'(sel) < NUM_IN) && in_valid[sel];

  // Round-robin search: scan rr_ptr+1 .. rr_ptr+NUM_IN (mod NUM_IN) and take
  // the first valid channel. rr_ptr always stays below NUM_IN, so a single
  // subtraction is enough for the wrap.
  always_comb begin : rr_search
    int idx;
    idx    = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      if (!rr_hit && in_valid[idx[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin : grant_sel
    grant     = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      grant     = fx_hit;
      grant_idx = sel;
    end else begin
      grant     = rr_hit;
      grant_idx = rr_idx;
`ifdef MUX_STREAM_LOCK_EN
      // While locked, rr_ptr still holds the locked channel. The transfer
      // that set the lock also wrote rr_ptr <= g.
      if (lock_q) begin
        grant     = in_valid[rr_ptr_q];
        grant_idx = rr_ptr_q;
      end
`endif
    end
  end

  assign load_en = !out_valid_q || out_ready;
  // Gating with rst_n keeps every in_ready low while reset is asserted.
  assign xfer    = rst_n && grant && load_en;

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_sel_d   = grant_idx;
      if (mode) begin
        rr_ptr_d = grant_idx;
      end
    end else if (out_ready) begin
      // Drain with nothing to replace it; data and sel keep their last value.
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX_STREAM_LOCK_EN
  always_comb begin : lock_next
    lock_d = lock_q;
    if (!mode) begin
      lock_d = 1'b0;
    end else if (xfer) begin
      lock_d = !in_last[grant_idx];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
`ifdef MUX_STREAM_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_STREAM_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_stream.sv
// tb_mux_stream -- self-checking bench for mux_stream.
// A directed vector table walks one known path through the design. Short
// hand-written sequences cover round-robin fairness, backpressure, reset
// mid-stream, an out-of-range select on a 3-input instance and (with
// MUX_STREAM_LOCK_EN) packet locking. A randomized phase is then checked
// against a behavioural model.
module tb_mux_stream;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;
`ifdef MUX_STREAM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic [SW-1:0] sel;
  logic          mode;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sel;

  // 3-input instance for the out-of-range select case
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_last3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic           mode3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3;
  logic [1:0]     out_sel3;

  always #5 clk = ~clk;

  mux_stream #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef MUX_STREAM_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  mux_stream #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
`ifdef MUX_STREAM_LOCK_EN
    .in_last(in_last3),
`endif
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit          m_v;
  logic [W-1:0] m_data;
  int          m_sel;
  int          m_ptr;
  bit          m_lock;

  typedef struct {
    logic        md;
    logic [1:0]  s;
    logic [3:0]  v;
    logic        rdy;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
  endtask

  // Grant from the rules: fixed select, lock, or first valid after the pointer.
  function automatic int model_grant();
    int c;
    if (mode == 1'b0) begin
      return in_valid[sel] ? int'(sel) : -1;
    end
    if (m_lock) begin
      c = m_ptr;
      return in_valid[2'(c)] ? m_ptr : -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[2'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic rand_cycle(input int n);
    int g;
    bit load;
    logic [N-1:0] exp_ir;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    in_valid  = 4'($urandom);
    in_last   = 4'($urandom);
    sel       = 2'($urandom);
    out_ready = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0) mode = ~mode;
    #1;
    g      = model_grant();
    load   = !m_v || out_ready;
    exp_ir = (g >= 0 && load) ? 4'(1 << g) : 4'b0000;
    chk("rand_in_ready", 32'(in_ready), 32'(exp_ir));
    if (g >= 0 && load) begin
      m_v    = 1'b1;
      m_data = in_data[g*W +: W];
      m_sel  = g;
      if (mode) begin
        m_ptr = g;
        if (LOCK_EN) m_lock = !in_last[2'(g)];
      end
    end else if (out_ready) begin
      m_v = 1'b0;
    end
    if (!mode) m_lock = 1'b0;
    tick();
    chk("rand_out_valid", 32'(out_valid), 32'(m_v));
    chk("rand_out_sel", 32'(out_sel), 32'(m_sel));
    chk("rand_out_data", out_data, m_data);
    $display("rand %0d mode=%0d valid=%b ready=%b g=%0d -> ov=%b sel=%0d data=%h",
             n, mode, in_valid, out_ready, g, out_valid, out_sel, out_data);
  endtask

  initial begin
    int rr_exp [6];
    rr_exp = '{0, 1, 3, 0, 1, 3};

    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[6]  = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[7]  = '{1'b1, 2'd3, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[9]  = '{1'b0, 2'd3, 4'b0111, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 2'd3, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[11] = '{1'b1, 2'd3, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[12] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};

    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hCAFE0000 | i;
    in_last    = '1;
    sel        = '0;
    mode       = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = 32'hD0000000 | i;
    in_valid3  = '0;
    in_last3   = '1;
    sel3       = '0;
    mode3      = 1'b0;
    out_ready3 = 1'b0;

    // reset state
    do_reset();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_sel", 32'(out_sel), 32'd0);

    // directed table
    for (int i = 0; i < 14; i++) begin
      mode      = vecs[i].md;
      sel       = vecs[i].s;
      in_valid  = vecs[i].v;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_out_data", i), out_data, 32'hCAFE0000 | 32'(vecs[i].exp_sel));
      $display("vec %0d mode=%0d sel=%0d valid=%b ready=%b -> in_ready=%b ov=%b out_sel=%0d",
               i, mode, sel, in_valid, out_ready, in_ready, out_valid, out_sel);
    end

    // backpressure: held beat from channel 3, pointer at 3
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", out_data, 32'hCAFE0003);
      $display("stall %0d in_ready=%b ov=%b data=%h", i, in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("unstall_out_sel", 32'(out_sel), 32'd0);
    chk("unstall_out_data", out_data, 32'hCAFE0000);
    $display("unstall ov=%b sel=%0d data=%h", out_valid, out_sel, out_data);

    // reset mid-operation: pointer is 0, so without reset channel 1 would win
    rst_n = 1'b0;
    #1;
    chk("in_reset_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_out_data", out_data, 32'd0);
    chk("midreset_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("post_reset_out_valid", 32'(out_valid), 32'd1);
    chk("post_reset_out_data", out_data, 32'hCAFE0000);
    $display("post-reset ov=%b sel=%0d data=%h", out_valid, out_sel, out_data);

    // round-robin fairness from reset, channel 2 idle
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1011;
    out_ready = 1'b1;
    in_last   = '1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'(1 << rr_exp[i]));
      tick();
      chk($sformatf("rr%0d_out_sel", i), 32'(out_sel), 32'(rr_exp[i]));
      $display("rr %0d out_sel=%0d ov=%b", i, out_sel, out_valid);
    end

    // out-of-range select on the 3-input instance
    mode3      = 1'b0;
    sel3       = 2'd1;
    in_valid3  = 3'b111;
    out_ready3 = 1'b0;
    #1;
    chk("oor_load_in_ready", 32'(in_ready3), 32'b010);
    tick();
    chk("oor_load_out_valid", 32'(out_valid3), 32'd1);
    sel3       = 2'd3;
    out_ready3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("oor_in_ready", 32'(in_ready3), 32'd0);
      tick();
      chk("oor_out_valid", 32'(out_valid3), 32'd0);
      chk("oor_out_sel", 32'(out_sel3), 32'd1);
      chk("oor_out_data", out_data3, 32'hD0000001);
      $display("oor %0d in_ready=%b ov=%b sel=%0d", i, in_ready3, out_valid3, out_sel3);
    end

`ifdef MUX_STREAM_LOCK_EN
    // packet lock: channel 0 sends three beats, last on the third
    begin
      int lk_exp [4];
      lk_exp = '{0, 0, 0, 1};
      do_reset();
      mode      = 1'b1;
      in_valid  = 4'b0011;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_last = (i == 2) ? 4'b0011 : 4'b0010;
        #1;
        chk($sformatf("lock%0d_in_ready", i), 32'(in_ready), 32'(1 << lk_exp[i]));
        tick();
        chk($sformatf("lock%0d_out_sel", i), 32'(out_sel), 32'(lk_exp[i]));
        $display("lock %0d out_sel=%0d", i, out_sel);
      end
    end
`endif

    // randomized phase against the model
    do_reset();
    mode   = 1'b0;
    m_v    = 1'b0;
    m_data = '0;
    m_sel  = 0;
    m_ptr  = N - 1;
    m_lock = 1'b0;
    for (int n = 0; n < 250; n++) rand_cycle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
